rom_read_arbiter: RTL and testbench

Shares one `single_port_rom`-style synchronous ROM between `NUM_REQ` independent readers. It accepts at most one read per cycle, chosen round-robin, and drives the ROM address port. It tracks which requester owns each in-flight read through the ROM's 1- or 2-cycle latency and returns the data to that requester with a one-cycle valid strobe. It sits between the ROM macro and client blocks such as table lookups and sequencers, so no client has to arbitrate the ROM itself.

---
 rtl/rom_ctrl_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 52 +++++
 rtl/rom_read_arbiter.sv | 96 +++++++++
 tb/tb_rom_read_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rom_ctrl_pkg.sv
// Shared helpers for ROM access blocks: ROM read latency and requester id sizing.
package rom_ctrl_pkg;

    localparam int MAX_REQ = 8;

    // The ROM's optional output register adds one cycle to the read.
    function automatic int rom_latency(input string output_reg);
        return (output_reg == "TRUE") ? 2 : 1;
    endfunction

    function automatic int id_width(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from rr_ptr, pointer
// moves past the winner whenever the grant is taken.
module rr_arbiter
    import rom_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = id_width(N);

    logic [PW-1:0] rr_ptr_reg;
    logic [PW-1:0] rr_ptr_next;
    logic [PW:0]   idx;
    logic          found;

    // idx carries one spare bit so the wrap works for non-power-of-two N.
    always_comb begin
        gnt         = '0;
        rr_ptr_next = rr_ptr_reg;
        found       = 1'b0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, rr_ptr_reg} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!found && req[idx[PW-1:0]]) begin
                found             = 1'b1;
                gnt[idx[PW-1:0]]  = 1'b1;
                rr_ptr_next       = (idx == (PW+1)'(N-1)) ? '0 : PW'(idx + 1'b1);
            end
        end
        if (rst) begin
            gnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (advance && found) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one synchronous ROM among NUM_REQ readers; tags each accepted read with
// its owner and strobes rsp_valid to that owner when the ROM data arrives.
module rom_read_arbiter
    import rom_ctrl_pkg::*;
#(
    parameter int    NUM_REQ    = 4,
    parameter int    ADDR_WIDTH = 8,
    parameter int    DATA_WIDTH = 16,
    parameter string OUTPUT_REG = "FALSE"
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data
);

    localparam int LAT = rom_latency(OUTPUT_REG);
    localparam int IW  = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]    gnt;
    logic                  grant_any;
    logic [IW-1:0]         gnt_id;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [ADDR_WIDTH-1:0] last_addr_reg;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

    logic [LAT-1:0]        tag_valid_reg;
    logic [IW-1:0]         tag_id_reg [LAT];

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (grant_any),
        .gnt     (gnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // gnt is one-hot, so the last match is the only match.
    always_comb begin
        gnt_id     = '0;
        grant_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id     = IW'(i);
                grant_addr = addr_arr[i];
            end
        end
    end

    assign grant_any = |gnt;
    assign req_ready = gnt;
    assign rom_addr  = grant_any ? grant_addr : last_addr_reg;
    assign rsp_data  = rom_data;

    // Tag pipeline mirrors the ROM latency so the owner id lines up with rom_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_reg <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_id_reg[s] <= '0;
            end
            last_addr_reg <= '0;
        end else begin
            tag_valid_reg[0] <= grant_any;
            tag_id_reg[0]    <= gnt_id;
            for (int s = 1; s < LAT; s++) begin
                tag_valid_reg[s] <= tag_valid_reg[s-1];
                tag_id_reg[s]    <= tag_id_reg[s-1];
            end
            if (grant_any) begin
                last_addr_reg <= grant_addr;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = tag_valid_reg[LAT-1] && (tag_id_reg[LAT-1] == IW'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Drives one L=1 and one L=2 arbiter with the same directed requests; expected
// responses go into per-instance queues checked by an independent monitor.
module tb_rom_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*AW-1:0] req_addr;

    logic [N-1:0]  ready1, ready2, rsp_valid1, rsp_valid2;
    logic [DW-1:0] rsp_data1, rsp_data2, rom_data1, rom_data2;
    logic [AW-1:0] rom_addr1, rom_addr2;

    rom_read_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG("FALSE")
    ) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .rom_addr(rom_addr1), .rom_data(rom_data1)
    );

    rom_read_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG("TRUE")
    ) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
        .rom_addr(rom_addr2), .rom_data(rom_data2)
    );

    // Behavioural ROMs: registered read, plus output register for the L=2 one.
    logic [DW-1:0] rom [256];
    logic [DW-1:0] rom_q1, rom_a2, rom_q2;
    always_ff @(posedge clk) begin
        rom_q1 <= rom[rom_addr1];
        rom_a2 <= rom[rom_addr2];
        rom_q2 <= rom_a2;
    end
    assign rom_data1 = rom_q1;
    assign rom_data2 = rom_q2;

    typedef struct {
        int          due;
        int          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    logic mon_en = 1'b0;
    logic [AW-1:0] addr_tb [N];
    logic [AW-1:0] exp_last = '0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc_n, act, exp);
        end
    endtask

    // Response monitor: every cycle either the queued response is due or nothing is.
    exp_t m1, m2;
    always @(negedge clk) begin
        if (mon_en) begin
            if (q1.size() > 0 && q1[0].due == cyc_n) begin
                m1 = q1.pop_front();
                $display("rsp L1 cycle=%0d id=%0d data=%h", cyc_n, m1.id, rsp_data1);
                chk("rsp_valid_l1", 32'(rsp_valid1), 32'(1) << m1.id);
                chk("rsp_data_l1", 32'(rsp_data1), 32'(m1.data));
            end else begin
                chk("idle_rsp_l1", 32'(rsp_valid1), 32'd0);
            end
            if (q2.size() > 0 && q2[0].due == cyc_n) begin
                m2 = q2.pop_front();
                $display("rsp L2 cycle=%0d id=%0d data=%h", cyc_n, m2.id, rsp_data2);
                chk("rsp_valid_l2", 32'(rsp_valid2), 32'(1) << m2.id);
                chk("rsp_data_l2", 32'(rsp_data2), 32'(m2.data));
            end else begin
                chk("idle_rsp_l2", 32'(rsp_valid2), 32'd0);
            end
        end
    end

    // One cycle of stimulus with the hand-computed grant (-1 = none).
    task automatic step(input logic [N-1:0] v, input int exp_g, input logic r);
        logic [N-1:0] exp_ready;
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_tb[i];
        @(negedge clk);
        exp_ready = (exp_g < 0) ? '0 : (N'(1) << exp_g);
        if (exp_g >= 0) exp_last = addr_tb[exp_g];
        $display("req cycle=%0d valid=%b rst=%0d expect_grant=%0d", cyc_n, v, r, exp_g);
        chk("req_ready_l1", 32'(ready1), 32'(exp_ready));
        chk("req_ready_l2", 32'(ready2), 32'(exp_ready));
        chk("rom_addr_l1", 32'(rom_addr1), 32'(exp_last));
        chk("rom_addr_l2", 32'(rom_addr2), 32'(exp_last));
        if (exp_g >= 0) begin
            e.id   = exp_g;
            e.data = rom[addr_tb[exp_g]];
            e.due  = cyc_n + 1;
            q1.push_back(e);
            e.due  = cyc_n + 2;
            q2.push_back(e);
        end
        if (r) begin
            exp_last = '0;
            for (int i = q1.size() - 1; i >= 0; i--) if (q1[i].due > cyc_n) q1.delete(i);
            for (int i = q2.size() - 1; i >= 0; i--) if (q2[i].due > cyc_n) q2.delete(i);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 16'((a * 16'h0101) ^ 16'h5A00);
        rom[8'h05] = 16'hBEEF;
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        for (int i = 0; i < N; i++) addr_tb[i] = 8'(8'h10 + i);

        @(posedge clk);
        #1 mon_en = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("reset_ready_l1", 32'(ready1), 32'd0);
        chk("reset_ready_l2", 32'(ready2), 32'd0);
        req_valid = '0;

        step(4'b0000, -1, 1'b0);
        // All four valid: strict rotation 0..3 twice.
        for (int k = 0; k < 8; k++) step(4'b1111, k % 4, 1'b0);
        for (int k = 0; k < 3; k++) step(4'b0000, -1, 1'b0);

        // Single read from requester 2 at 0x05.
        addr_tb[2] = 8'h05;
        step(4'b0100, 2, 1'b0);
        for (int k = 0; k < 3; k++) step(4'b0000, -1, 1'b0);

        // Fairness: after a grant to 1, requesters 1 and 3 alternate.
        addr_tb[1] = 8'h21;
        addr_tb[3] = 8'h23;
        step(4'b0010, 1, 1'b0);
        step(4'b1010, 3, 1'b0);
        step(4'b1010, 1, 1'b0);
        step(4'b1010, 3, 1'b0);
        step(4'b1010, 1, 1'b0);
        // Pointer at 2: requester 3 wins over 0, then 0 is served.
        addr_tb[0] = 8'h30;
        step(4'b1001, 3, 1'b0);
        step(4'b1001, 0, 1'b0);
        for (int k = 0; k < 3; k++) step(4'b0000, -1, 1'b0);

        // Reset mid-flight: L=2 response is discarded, pointer restarts at 0.
        addr_tb[2] = 8'h40;
        step(4'b0100, 2, 1'b0);
        step(4'b1100, -1, 1'b1);
        step(4'b1100, 2, 1'b0);
        step(4'b1000, 3, 1'b0);
        for (int k = 0; k < 3; k++) step(4'b0000, -1, 1'b0);

        // Idle hold: rom_addr keeps the last granted address.
        addr_tb[0] = 8'h7A;
        step(4'b0001, 0, 1'b0);
        for (int k = 0; k < 5; k++) step(4'b0000, -1, 1'b0);

        chk("queues_drained", 32'(q1.size() + q2.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
